// File: rtl/lz4_pkg.sv
// Shared types and constants for the LZ4 block feeder.
package lz4_pkg;

    typedef enum logic [1:0] {
        HDR,
        PAY,
        ERR
    } lz4_state_e;

    localparam int unsigned LZ4_RAW_FLAG_BIT = 31;
    localparam logic [31:0] LZ4_ENDMARK      = 32'h0;
    localparam int unsigned LZ4_MAX_BLOCK    = 4194304;

endpackage

// File: rtl/lz4_word_unpacker.sv
// Holds one input word and hands it out a byte at a time, byte 0 first.
module lz4_word_unpacker #(
    parameter int unsigned word_size = 8,
    parameter int unsigned in_width  = 32,
    localparam int unsigned BYTES    = in_width / word_size,
    localparam int unsigned CNT_W    = $clog2(BYTES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_W-1:0]     load_cnt,
    input  logic [in_width-1:0]  load_word,
    input  logic                 advance,
    output logic [word_size-1:0] byte_out,
    output logic                 empty,
    output logic                 last
);

    logic [in_width-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // A load always wins: the top only loads when the buffer is empty or
    // its last byte leaves on the same edge.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (load) begin
            buf_d = load_word;
            cnt_d = load_cnt;
        end else if (advance && cnt_q != '0) begin
            buf_d = buf_q >> word_size;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign byte_out = buf_q[word_size-1:0];
    assign empty    = (cnt_q == '0);
    assign last     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lz4_block_feeder.sv
// Strips LZ4 block headers and serialises payload words into one byte per
// cycle for the decompressor, tracking raw, oversize and end-mark headers.
module lz4_block_feeder
    import lz4_pkg::*;
#(
    parameter int unsigned word_size       = 8,
    parameter int unsigned in_width        = 32,
    parameter int unsigned max_block_bytes = LZ4_MAX_BLOCK,
    parameter int unsigned cnt_width       = 23
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [in_width-1:0]  in_word,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 dec_ready,
    output logic [word_size-1:0] compressed_word,
    output logic                 write,
    output logic                 raw_block,
    output logic                 block_start,
    output logic                 block_done,
    output logic                 frame_end,
    output logic                 error
);

    localparam int unsigned BYTES  = in_width / word_size;
    localparam int unsigned CNT_W  = $clog2(BYTES + 1);
    localparam int unsigned SIZE_W = LZ4_RAW_FLAG_BIT;

    lz4_state_e             state_q, state_d;
    logic [cnt_width-1:0]   rem_q, rem_d, rem_dec;
    logic                   ready_en_q, ready_en_d;
    logic [word_size-1:0]   cw_q, cw_d;
    logic                   write_q, write_d;
    logic                   raw_q, raw_d;
    logic                   start_q, start_d;
    logic                   done_q, done_d;
    logic                   fe_q, fe_d;
    logic                   err_q, err_d;

    logic                   load, advance, buf_empty, buf_last, in_ready_c, take;
    logic [CNT_W-1:0]       load_cnt;
    logic [word_size-1:0]   byte_out;
    logic [SIZE_W-1:0]      hdr_size;

    lz4_word_unpacker #(
        .word_size (word_size),
        .in_width  (in_width)
    ) u_unpacker (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_cnt  (load_cnt),
        .load_word (in_word),
        .advance   (advance),
        .byte_out  (byte_out),
        .empty     (buf_empty),
        .last      (buf_last)
    );

    assign hdr_size = in_word[SIZE_W-1:0];

    // Accept a new word only if the block still has bytes beyond the buffer.
    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            HDR:     in_ready_c = ready_en_q;
            PAY:     in_ready_c = (buf_empty && rem_q != '0) ||
                                  (buf_last && dec_ready && rem_q > cnt_width'(1));
            default: in_ready_c = 1'b0;
        endcase
    end

    assign take     = in_valid && in_ready_c;
    assign in_ready = in_ready_c;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        rem_dec    = rem_q;
        ready_en_d = 1'b1;
        cw_d       = cw_q;
        write_d    = 1'b0;
        raw_d      = raw_q;
        start_d    = 1'b0;
        done_d     = 1'b0;
        fe_d       = 1'b0;
        err_d      = err_q;
        load       = 1'b0;
        advance    = 1'b0;
        load_cnt   = '0;
        case (state_q)
            HDR: begin
                raw_d = 1'b0;
                if (take) begin
                    if (in_word == LZ4_ENDMARK) begin
                        fe_d = 1'b1;
                    end else if (hdr_size > SIZE_W'(max_block_bytes)) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        rem_d   = cnt_width'(hdr_size);
                        raw_d   = in_word[LZ4_RAW_FLAG_BIT];
                        start_d = 1'b1;
                        state_d = PAY;
                    end
                end
            end
            PAY: begin
                advance = dec_ready && !buf_empty;
                if (advance) begin
                    rem_dec = rem_q - cnt_width'(1);
                    write_d = 1'b1;
                    cw_d    = byte_out;
                end
                rem_d    = rem_dec;
                load     = take;
                load_cnt = (rem_dec >= cnt_width'(BYTES)) ? CNT_W'(BYTES) : CNT_W'(rem_dec);
                // Also covers the empty raw block, which arrives here with rem_q == 0.
                if (rem_dec == '0) begin
                    done_d  = 1'b1;
                    state_d = HDR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HDR;
            rem_q      <= '0;
            ready_en_q <= 1'b0;
            cw_q       <= '0;
            write_q    <= 1'b0;
            raw_q      <= 1'b0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            fe_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            ready_en_q <= ready_en_d;
            cw_q       <= cw_d;
            write_q    <= write_d;
            raw_q      <= raw_d;
            start_q    <= start_d;
            done_q     <= done_d;
            fe_q       <= fe_d;
            err_q      <= err_d;
        end
    end

    assign compressed_word = cw_q;
    assign write           = write_q;
    assign raw_block       = raw_q;
    assign block_start     = start_q;
    assign block_done      = done_q;
    assign frame_end       = fe_q;
    assign error           = err_q;

endmodule

// File: tb/tb_lz4_block_feeder.sv
// Directed bench for lz4_block_feeder: cycle table plus backpressure,
// oversize-header and mid-block reset sequences.
module tb_lz4_block_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic        dec_ready;
    logic [7:0]  compressed_word;
    logic        write;
    logic        raw_block;
    logic        block_start;
    logic        block_done;
    logic        frame_end;
    logic        error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lz4_block_feeder dut (
        .clk             (clk),
        .reset           (reset),
        .in_word         (in_word),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .dec_ready       (dec_ready),
        .compressed_word (compressed_word),
        .write           (write),
        .raw_block       (raw_block),
        .block_start     (block_start),
        .block_done      (block_done),
        .frame_end       (frame_end),
        .error           (error)
    );

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic        dr;
        logic        rdy;
        logic        wr;
        logic [7:0]  b;
        logic        st;
        logic        dn;
        logic        fe;
        logic        raw;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] blk   [4]  = '{32'h0000000B, 32'h0001311F, 32'h31315001, 32'h00313131};
    logic [7:0]  exp_b [11] = '{8'd31, 8'd49, 8'd1, 8'd0, 8'd1, 8'd80, 8'd49, 8'd49, 8'd49, 8'd49, 8'd49};

    function automatic vec_t mk(input logic v, input logic [31:0] w, input logic dr,
                                input logic rdy, input logic wr, input logic [7:0] b,
                                input logic st, input logic dn, input logic fe, input logic raw);
        vec_t r;
        r.v = v; r.w = w; r.dr = dr; r.rdy = rdy; r.wr = wr; r.b = b;
        r.st = st; r.dn = dn; r.fe = fe; r.raw = raw;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_word = '0; dec_ready = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_write", 32'(write), 0);
        chk("rst_cw", 32'(compressed_word), 0);
        chk("rst_raw", 32'(raw_block), 0);
        chk("rst_start", 32'(block_start), 0);
        chk("rst_done", 32'(block_done), 0);
        chk("rst_fe", 32'(frame_end), 0);
        chk("rst_error", 32'(error), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_write", 32'(write), 0);
    endtask

    // Feeds the 11-byte block, tracking buffered bytes from what was loaded
    // versus what has come out.
    task automatic stream(input bit toggle, input int stop_after, output int nbytes);
        int  wi = 0, loaded = 0, got = 0, cyc = 0;
        logic take;
        while (got < stop_after && cyc < 300) begin
            @(negedge clk);
            dec_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            in_valid  = (wi < 4);
            in_word   = (wi < 4) ? blk[wi] : 32'h0;
            #1;
            chk("ready_with_2plus_buffered", 32'(in_ready && (loaded - got) > 1), 0);
            take = in_valid && in_ready;
            @(posedge clk); #1;
            if (take) begin
                if (wi > 0) loaded += ((11 - 4 * (wi - 1)) > 4) ? 4 : (11 - 4 * (wi - 1));
                wi++;
            end
            if (write) begin
                chk("write_needs_dec_ready", 32'(dec_ready), 1);
                if (got < 11) chk($sformatf("byte%0d", got), 32'(compressed_word), 32'(exp_b[got]));
                else chk("extra_byte_written", 32'(write), 0);
                got++;
                chk("block_done_on_last", 32'(block_done), 32'(got == 11));
            end
            cyc++;
        end
        nbytes = got;
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; in_word = '0; dec_ready = 1'b1;
        do_reset();

        vecs.push_back(mk(1, 32'h0000000B, 1, 1, 0, 8'h00, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h0001311F, 1, 1, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h31315001, 1, 0, 1, 8'h1F, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h31315001, 1, 0, 1, 8'h31, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h31315001, 1, 0, 1, 8'h01, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h31315001, 1, 1, 1, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00313131, 1, 0, 1, 8'h01, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00313131, 1, 0, 1, 8'h50, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00313131, 1, 0, 1, 8'h31, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00313131, 1, 1, 1, 8'h31, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hFFFFFFFF, 1, 0, 1, 8'h31, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hFFFFFFFF, 1, 0, 1, 8'h31, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'hFFFFFFFF, 1, 0, 1, 8'h31, 0, 1, 0, 0));
        vecs.push_back(mk(1, 32'h00000000, 1, 1, 0, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mk(0, 32'h00000000, 1, 1, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h80000004, 1, 1, 0, 8'h00, 1, 0, 0, 1));
        vecs.push_back(mk(1, 32'h44332211, 1, 1, 0, 8'h00, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h00000000, 1, 0, 1, 8'h11, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h00000000, 1, 0, 1, 8'h22, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h00000000, 1, 0, 1, 8'h33, 0, 0, 0, 1));
        vecs.push_back(mk(0, 32'h00000000, 1, 0, 1, 8'h44, 0, 1, 0, 1));
        vecs.push_back(mk(0, 32'h00000000, 1, 1, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h80000000, 1, 1, 0, 8'h00, 1, 0, 0, 1));
        vecs.push_back(mk(0, 32'h00000000, 1, 0, 0, 8'h00, 0, 1, 0, 1));
        vecs.push_back(mk(0, 32'h00000000, 1, 1, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 32'h00400000, 1, 1, 0, 8'h00, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = vecs[i].v; in_word = vecs[i].w; dec_ready = vecs[i].dr;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d_write", i), 32'(write), 32'(vecs[i].wr));
            if (vecs[i].wr) chk($sformatf("v%0d_byte", i), 32'(compressed_word), 32'(vecs[i].b));
            chk($sformatf("v%0d_start", i), 32'(block_start), 32'(vecs[i].st));
            chk($sformatf("v%0d_done", i), 32'(block_done), 32'(vecs[i].dn));
            chk($sformatf("v%0d_frame_end", i), 32'(frame_end), 32'(vecs[i].fe));
            chk($sformatf("v%0d_raw", i), 32'(raw_block), 32'(vecs[i].raw));
            chk($sformatf("v%0d_error", i), 32'(error), 0);
        end

        // Backpressure: dec_ready toggles 1,0,1,0.
        do_reset();
        stream(1'b1, 11, n);
        chk("bp_byte_count", 32'(n), 11);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0; dec_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp_no_extra_write", 32'(write), 0);
        end
        chk("bp_back_in_hdr", 32'(in_ready), 1);

        // Oversize header locks up until reset.
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'h00400001;
        @(posedge clk); #1;
        chk("ovs_error", 32'(error), 1);
        chk("ovs_in_ready", 32'(in_ready), 0);
        chk("ovs_start", 32'(block_start), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_word = 32'h0;
            #1;
            chk("err_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            chk("err_frame_end", 32'(frame_end), 0);
            chk("err_sticky", 32'(error), 1);
            chk("err_write", 32'(write), 0);
        end
        do_reset();

        // Reset after the 5th byte, then an end mark.
        stream(1'b0, 5, n);
        chk("mid_byte_count", 32'(n), 5);
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in_word = 32'h0; dec_ready = 1'b1;
        @(posedge clk); #1;
        chk("mid_frame_end", 32'(frame_end), 1);
        chk("mid_write", 32'(write), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk("mid_no_stale_write", 32'(write), 0);
            chk("mid_fe_pulse", 32'(frame_end), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lz4_block_feeder.md
Name: lz4_block_feeder

Overview:
- Upstream stage of the LZ4 decompressor. Takes a 32-bit little-endian LZ4 block stream from the system bus: a size header word, then the payload words.
- Serialises the payload into one byte per cycle on the decompressor's `compressed_word`/`write` inputs.
- Strips block headers and honours the end mark.
- Flags raw (uncompressed) blocks and flags oversize blocks.

Parameters:
- word_size, 8, byte width driven to the decompressor; fixed at 8 by the LZ4 format.
- in_width, 32, input bus width; must equal 4*word_size.
- max_block_bytes, 4194304, largest legal block size; a larger header is an error.
- cnt_width, 23, width of the remaining-byte counter; must satisfy 2^cnt_width > max_block_bytes.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_word  in  in_width  input word; byte 0 is in bits [7:0].
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts in_word this cycle.
- dec_ready  in  1  downstream can take a byte this cycle; tie high when unused.
- compressed_word  out  word_size  byte to the decompressor.
- write  out  1  compressed_word is valid this cycle.
- raw_block  out  1  current block is uncompressed (header bit 31 set); level, held for the whole payload.
- block_start  out  1  one-cycle pulse when a non-zero header is accepted.
- block_done  out  1  one-cycle pulse in the cycle the last payload byte is written.
- frame_end  out  1  one-cycle pulse when an all-zero end-mark header is accepted.
- error  out  1  sticky; set by an oversize header, cleared only by reset.

Behaviour:
- Reset values:
  - Outputs: in_ready=0, write=0, compressed_word=0, raw_block=0, block_start=0, block_done=0, frame_end=0, error=0.
  - Internal: state=HDR, remaining count=0, byte buffer empty.
  - in_ready rises in the first cycle after reset deasserts.
- A word transfers on a clock edge where in_valid && in_ready. All outputs are registered.
- States: HDR, PAY, ERR.
- HDR:
  - in_ready=1.
  - On transfer, size = in_word[30:0] and raw flag = in_word[31].
  - size==0 and raw==0: pulse frame_end, stay in HDR.
  - size > max_block_bytes: set error, go to ERR.
  - Otherwise: load remaining=size, latch raw_block, pulse block_start, go to PAY.
  - size==0 with raw==1 counts as an empty block: block_start then block_done one cycle apart, return to HDR, no write.
- PAY:
  - A 4-byte buffer holds buf_cnt bytes, where buf_cnt = min(4, remaining) when loaded.
  - in_ready = (buf_cnt==0) || (buf_cnt==1 && dec_ready), so consecutive words stream back-to-back.
  - Each cycle with dec_ready=1 and buf_cnt>0: drive the next byte (LE order), write=1 on the following edge, then decrement buf_cnt and remaining.
  - dec_ready=0 holds the byte buffer and counters. Bytes are presented only when dec_ready was high in the previous cycle.
  - When remaining reaches 0: pulse block_done coincident with the final write, clear raw_block, go to HDR.
  - Unused upper bytes of the final word are discarded.
- ERR: in_ready=0, write=0, output unchanged until reset.
- Latency: header accepted at edge N; first payload word accepted at edge N+1 at the earliest; its byte 0 appears with write=1 after edge N+2.
- Throughput: 1 byte/cycle sustained while in_valid and dec_ready stay high.
- in_valid low mid-block: write deasserts once the buffer drains; resume seamlessly when in_valid returns.
- Reset asserted mid-block: all state cleared at that edge and the partial block is abandoned. The decompressor is reset by the same signal.
- Counter arithmetic is unsigned. remaining never underflows, because buf_cnt is clamped to remaining.

Decomposition:
- Package lz4_pkg holds:
  - The state enum {HDR, PAY, ERR}.
  - LZ4_RAW_FLAG_BIT=31.
  - LZ4_ENDMARK=32'h0.
  - LZ4_MAX_BLOCK default.
- One sub-module: lz4_word_unpacker, the 4-byte buffer plus buf_cnt, taking load/advance controls and giving out byte/empty/last. The FSM and counters stay in the top module.

Test Plan:
- 11-byte block: header 0x0000000B, then 0x0001311F, 0x31315001, 0x00313131 → write bytes 31,49,1,0,1,80,49,49,49,49,49 on 11 consecutive cycles; block_done on the 11th; 12th byte never written.
- End mark: word 0x00000000 in HDR → frame_end=1 for one cycle, write stays 0, in_ready stays 1.
- Raw block: header 0x80000004, then 0x44332211 → raw_block=1 during bytes 0x11,0x22,0x33,0x44; raw_block=0 after block_done.
- Backpressure: same 11-byte block with dec_ready toggling 1,0,1,0 → same byte order, no byte written twice, in_ready never high while 2+ bytes are buffered.
- Oversize header: 0x00400001 → error=1 and in_ready=0 permanently; reset clears both.
- Reset mid-block: assert reset after the 5th byte, then send the end mark → frame_end pulses and no stale bytes are written.
